pag_xlate_cache: RTL and testbench
==================================

Name: pag_xlate_cache

Overview:
- Parametrised successor to the single-way KL10 pager page table.
- N-way set-associative virtual-to-physical page translation cache with per-set tag directory, round-robin replacement, odd-parity protection and an autonomous refill handshake toward the MBOX page-refill logic.
- Runs a hardware directory sweep at reset and on request.
- Produces KL10-style page-fail codes so the EBOX/MCL trap path consumes it unchanged.

Parameters:
- WAYS, 2, associativity (1..4).
- SETS_LOG2, 7, log2 sets; VPN low bits index the set.
- VPN_W, 14, virtual page number width (VMA 13:26).
- PPN_W, 13, physical page number width (PT 14:26).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- lk_valid  in  1  lookup request
- lk_ready  out  1  lookup accepted this cycle when lk_valid&lk_ready
- lk_user  in  1  user-mode reference (part of tag)
- lk_vpn  in  VPN_W  virtual page number
- lk_write  in  1  write reference
- rsp_valid  out  1  one-cycle response strobe
- rsp_ppn  out  PPN_W  translated page
- rsp_cache  out  1  cacheable
- rsp_fail  out  1  page fail
- rsp_code  out  5  fail code {refill_err, access, writable, software, write}
- rf_req  out  1  refill request, held until rf_valid
- rf_user  out  1  refill user bit
- rf_vpn  out  VPN_W  refill vpn
- rf_valid  in  1  refill data strobe
- rf_err  in  1  refill error
- rf_entry  in  5+PPN_W  {access, public, writable, software, cache, ppn}
- sweep_req  in  1  clear all entries (pulse)
- busy  out  1  sweep or refill in progress
- par_inject  in  1  test: invert stored parity on next write

Behaviour:
- Reset: all outputs 0; FSM enters SWEEP with set pointer 0; replacement pointers 0. Reset mid-operation abandons any refill: rf_req drops next cycle and no response is issued.
- Storage: per way, per set, one entry {valid, user, vpn tag bits above SETS_LOG2, flags[5], ppn, par}. par makes flags+ppn odd parity (XOR of those bits XOR par = 1).
- States:
  - SWEEP: clears valid for one set per cycle, all ways. 2^SETS_LOG2 cycles, then IDLE. lk_ready=0, busy=1.
  - IDLE: lk_ready=1 unless a sweep is pending. On accept, register the request and read all ways -> LOOKUP.
  - LOOKUP, one cycle: hit = valid & user match & tag match, in exactly one way.
    - Good-parity hit: rsp_valid next edge with entry data -> IDLE. Hit latency 2 cycles from accept.
    - Miss: victim = lowest-index invalid way, else that set's round-robin pointer -> REFILL.
    - Multiple-way hit: treated as parity error.
    - Parity error: invalidate the hit way(s) and treat as miss.
  - REFILL: rf_req=1 with the registered user/vpn; lk_ready=0.
    - On rf_valid with rf_err=0: write entry to victim, advance pointer only if victim came from the pointer -> RESP.
    - On rf_valid with rf_err=1: nothing written, respond fail with code[4]=1 -> IDLE.
  - RESP: respond from the just-written entry -> IDLE.
- Fail rule:
  - fail = refill_err | ~access | (lk_write & ~writable).
  - rsp_code = {rf_err, access, writable, software, lk_write}.
  - rsp_ppn is still driven on fail; the consumer ignores it.
- Sweep: sweep_req in IDLE enters SWEEP next cycle. A sweep_req during LOOKUP/REFILL/RESP is latched and taken on return to IDLE, after the response. Repeated requests while one is pending merge.
- Simultaneous lk_valid and pending sweep: sweep wins, lk_ready=0.
- par_inject flips the stored par bit on the next entry write only, then self-clears.
- Only one outstanding lookup at a time; no pipelining.

Test Plan:
- Reset, then hold lk_valid -> lk_ready stays 0 for 128 cycles, rises on cycle 129; busy falls at the same time.
- Lookup user=1 vpn=0x0123 (miss) -> rf_req with rf_vpn=0x0123. Supply rf_entry access=1 writable=1 cache=1 ppn=0x0456 -> rsp ppn=0x0456 fail=0. Repeat lookup -> hit, rsp 2 cycles after accept, rf_req stays 0.
- Write lookup to an entry with writable=0 -> rsp_fail=1, rsp_code=5'b01001. An exec lookup to the same vpn -> miss (user bit distinguishes).
- Fill three vpns mapping to set 5 with WAYS=2 -> third fill replaces way 0 and a fourth replaces way 1. Re-lookup the first vpn -> miss.
- par_inject during a fill, then re-lookup -> no hit, new rf_req issued, entry refilled cleanly. rf_err=1 refill -> rsp_fail=1, code[4]=1, nothing cached.
- sweep_req pulsed while REFILL is waiting -> response delivered first, then 128-cycle sweep. All earlier vpns miss afterwards.

Source files
------------

// File: rtl/pag_xlate_cache_if.sv
// Lookup / response / refill bundle for the page translation cache.
//   master : requester side (EBOX lookup source and MBOX refill source)
//   slave  : the translation cache itself
// Lookup   : lk_valid/lk_ready handshake carrying lk_user, lk_vpn, lk_write.
// Response : rsp_valid one-cycle strobe with rsp_ppn, rsp_cache, rsp_fail, rsp_code.
// Refill   : rf_req held with rf_user/rf_vpn until the rf_valid strobe returns
//            rf_err and rf_entry = {access, public, writable, software, cache, ppn}.
interface pag_xlate_cache_if #(
  parameter int VPN_W = 14,
  parameter int PPN_W = 13
);
  logic             lk_valid;
  logic             lk_ready;
  logic             lk_user;
  logic [VPN_W-1:0] lk_vpn;
  logic             lk_write;
  logic             rsp_valid;
  logic [PPN_W-1:0] rsp_ppn;
  logic             rsp_cache;
  logic             rsp_fail;
  logic [4:0]       rsp_code;
  logic             rf_req;
  logic             rf_user;
  logic [VPN_W-1:0] rf_vpn;
  logic             rf_valid;
  logic             rf_err;
  logic [PPN_W+4:0] rf_entry;

  modport master (
    output lk_valid, lk_user, lk_vpn, lk_write, rf_valid, rf_err, rf_entry,
    input  lk_ready, rsp_valid, rsp_ppn, rsp_cache, rsp_fail, rsp_code,
           rf_req, rf_user, rf_vpn
  );

  modport slave (
    input  lk_valid, lk_user, lk_vpn, lk_write, rf_valid, rf_err, rf_entry,
    output lk_ready, rsp_valid, rsp_ppn, rsp_cache, rsp_fail, rsp_code,
           rf_req, rf_user, rf_vpn
  );
endinterface

// File: rtl/pag_xlate_cache.sv
// N-way set-associative virtual-to-physical page translation cache.
// Per-set tag directory, round-robin replacement, odd parity over flags+ppn,
// autonomous refill toward MBOX, KL10-style page-fail codes, and a directory
// sweep at reset and on request.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus         : lookup / response / refill bundle (slave side)
//   sweep_req   : pulse to clear all entries
//   busy        : sweep or refill in progress
//   par_inject  : invert the stored parity bit of the next entry write
module pag_xlate_cache #(
  parameter int WAYS      = 2,   // 1..4
  parameter int SETS_LOG2 = 7,
  parameter int VPN_W     = 14,
  parameter int PPN_W     = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  pag_xlate_cache_if.slave        bus,
  input  logic                    sweep_req,
  output logic                    busy,
  input  logic                    par_inject
);
  localparam int SETS  = 1 << SETS_LOG2;
  localparam int TAG_W = VPN_W - SETS_LOG2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int ENT_W = 5 + PPN_W;   // {access, public, writable, software, cache, ppn}

  typedef enum logic [2:0] {S_SWEEP, S_IDLE, S_LOOKUP, S_REFILL, S_RESP} state_t;

  // Parity bit that makes {entry, par} odd.
  function automatic logic par_of(input logic [ENT_W-1:0] e);
    return ~^e;
  endfunction

  function automatic logic is_fail(input logic err, input logic [4:0] fl, input logic wr);
    return err | ~fl[4] | (wr & ~fl[2]);
  endfunction

  function automatic logic [4:0] fail_code(input logic err, input logic [4:0] fl, input logic wr);
    return {err, fl[4], fl[2], fl[1], wr};
  endfunction

  function automatic logic [WAY_W-1:0] next_ptr(input logic [WAY_W-1:0] p);
    return (p == WAY_W'(WAYS-1)) ? '0 : p + 1'b1;
  endfunction

  state_t               state;
  logic                 valid_mem [WAYS][SETS];
  logic                 user_mem  [WAYS][SETS];
  logic [TAG_W-1:0]     tag_mem   [WAYS][SETS];
  logic [ENT_W-1:0]     ent_mem   [WAYS][SETS];
  logic                 par_mem   [WAYS][SETS];
  logic [WAY_W-1:0]     rr_ptr    [SETS];

  logic [SETS_LOG2-1:0] sweep_set;
  logic                 sweep_pend, inj_pend;

  logic                 req_user_p1, req_write_p1;
  logic [VPN_W-1:0]     req_vpn_p1;
  logic                 rd_valid_p1 [WAYS];
  logic                 rd_user_p1  [WAYS];
  logic [TAG_W-1:0]     rd_tag_p1   [WAYS];
  logic [ENT_W-1:0]     rd_ent_p1   [WAYS];
  logic                 rd_par_p1   [WAYS];
  logic [WAY_W-1:0]     vic_way_p2;
  logic                 vic_ptr_p2;
  logic [ENT_W-1:0]     resp_ent_p2;

  logic                 rsp_valid_q, rsp_cache_q, rsp_fail_q;
  logic [PPN_W-1:0]     rsp_ppn_q;
  logic [4:0]           rsp_code_q;
  logic                 rf_req_q, rf_user_q;
  logic [VPN_W-1:0]     rf_vpn_q;

  logic [SETS_LOG2-1:0] lk_idx, req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic                 accept, fill_we;
  logic [WAYS-1:0]      hit_vec;
  logic [2:0]           hit_cnt;
  logic [WAY_W-1:0]     hit_way, free_way;
  logic                 hit_good, has_free;

  assign lk_idx  = bus.lk_vpn[SETS_LOG2-1:0];
  assign req_idx = req_vpn_p1[SETS_LOG2-1:0];
  assign req_tag = req_vpn_p1[VPN_W-1:SETS_LOG2];

  // A pending or just-arriving sweep blocks new lookups.
  assign bus.lk_ready = (state == S_IDLE) && !sweep_pend && !sweep_req;
  assign accept       = bus.lk_ready && bus.lk_valid;
  assign fill_we      = (state == S_REFILL) && bus.rf_valid && !bus.rf_err;
  assign busy         = (state == S_SWEEP) || (state == S_REFILL);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_ppn   = rsp_ppn_q;
  assign bus.rsp_cache = rsp_cache_q;
  assign bus.rsp_fail  = rsp_fail_q;
  assign bus.rsp_code  = rsp_code_q;
  assign bus.rf_req    = rf_req_q;
  assign bus.rf_user   = rf_user_q;
  assign bus.rf_vpn    = rf_vpn_q;

  // Lookup compare. A clean hit needs exactly one matching way with good
  // parity; anything else is a miss whose matching ways become free victims.
  always_comb begin
    hit_vec  = '0;
    hit_cnt  = '0;
    hit_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = rd_valid_p1[w] && (rd_user_p1[w] == req_user_p1) && (rd_tag_p1[w] == req_tag);
      if (hit_vec[w]) begin
        hit_cnt = hit_cnt + 3'd1;
        hit_way = WAY_W'(w);
      end
    end
    hit_good = (hit_cnt == 3'd1) && (^{rd_ent_p1[hit_way], rd_par_p1[hit_way]});
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!rd_valid_p1[w] || hit_vec[w]) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  // Control path: FSM, valid bits, replacement pointers, registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_SWEEP;
      sweep_set   <= '0;
      sweep_pend  <= 1'b0;
      inj_pend    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ppn_q   <= '0;
      rsp_cache_q <= 1'b0;
      rsp_fail_q  <= 1'b0;
      rsp_code_q  <= '0;
      rf_req_q    <= 1'b0;
      rf_user_q   <= 1'b0;
      rf_vpn_q    <= '0;
      vic_way_p2  <= '0;
      vic_ptr_p2  <= 1'b0;
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (par_inject) inj_pend <= 1'b1;
      if (sweep_req && (state == S_LOOKUP || state == S_REFILL || state == S_RESP))
        sweep_pend <= 1'b1;
      case (state)
        S_SWEEP: begin
          for (int w = 0; w < WAYS; w++) valid_mem[w][sweep_set] <= 1'b0;
          sweep_set <= sweep_set + 1'b1;
          if (sweep_set == {SETS_LOG2{1'b1}}) state <= S_IDLE;
        end
        S_IDLE: begin
          if (sweep_req || sweep_pend) begin
            state      <= S_SWEEP;
            sweep_set  <= '0;
            sweep_pend <= 1'b0;
          end else if (accept) begin
            state <= S_LOOKUP;
            for (int w = 0; w < WAYS; w++) rd_valid_p1[w] <= valid_mem[w][lk_idx];
          end
        end
        S_LOOKUP: begin
          if (hit_good) begin
            rsp_valid_q <= 1'b1;
            rsp_ppn_q   <= rd_ent_p1[hit_way][PPN_W-1:0];
            rsp_cache_q <= rd_ent_p1[hit_way][PPN_W];
            rsp_fail_q  <= is_fail(1'b0, rd_ent_p1[hit_way][ENT_W-1:PPN_W], req_write_p1);
            rsp_code_q  <= fail_code(1'b0, rd_ent_p1[hit_way][ENT_W-1:PPN_W], req_write_p1);
            state       <= S_IDLE;
          end else begin
            for (int w = 0; w < WAYS; w++)
              if (hit_vec[w]) valid_mem[w][req_idx] <= 1'b0;
            vic_way_p2 <= has_free ? free_way : rr_ptr[req_idx];
            vic_ptr_p2 <= !has_free;
            rf_req_q   <= 1'b1;
            rf_user_q  <= req_user_p1;
            rf_vpn_q   <= req_vpn_p1;
            state      <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (bus.rf_valid) begin
            rf_req_q <= 1'b0;
            if (bus.rf_err) begin
              rsp_valid_q <= 1'b1;
              rsp_ppn_q   <= bus.rf_entry[PPN_W-1:0];
              rsp_cache_q <= bus.rf_entry[PPN_W];
              rsp_fail_q  <= 1'b1;
              rsp_code_q  <= fail_code(1'b1, bus.rf_entry[ENT_W-1:PPN_W], req_write_p1);
              state       <= S_IDLE;
            end else begin
              valid_mem[vic_way_p2][req_idx] <= 1'b1;
              if (vic_ptr_p2) rr_ptr[req_idx] <= next_ptr(rr_ptr[req_idx]);
              inj_pend <= 1'b0;
              state    <= S_RESP;
            end
          end
        end
        S_RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_ppn_q   <= resp_ent_p2[PPN_W-1:0];
          rsp_cache_q <= resp_ent_p2[PPN_W];
          rsp_fail_q  <= is_fail(1'b0, resp_ent_p2[ENT_W-1:PPN_W], req_write_p1);
          rsp_code_q  <= fail_code(1'b0, resp_ent_p2[ENT_W-1:PPN_W], req_write_p1);
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data path: request capture, directory read, entry write.
  always_ff @(posedge clk) begin
    // p1: request registered and all ways of the set read
    if (accept) begin
      req_user_p1  <= bus.lk_user;
      req_write_p1 <= bus.lk_write;
      req_vpn_p1   <= bus.lk_vpn;
      for (int w = 0; w < WAYS; w++) begin
        rd_user_p1[w] <= user_mem[w][lk_idx];
        rd_tag_p1[w]  <= tag_mem[w][lk_idx];
        rd_ent_p1[w]  <= ent_mem[w][lk_idx];
        rd_par_p1[w]  <= par_mem[w][lk_idx];
      end
    end
    // p2: refill data written to the victim way
    if (fill_we) begin
      user_mem[vic_way_p2][req_idx] <= req_user_p1;
      tag_mem[vic_way_p2][req_idx]  <= req_tag;
      ent_mem[vic_way_p2][req_idx]  <= bus.rf_entry;
      par_mem[vic_way_p2][req_idx]  <= par_of(bus.rf_entry) ^ (inj_pend | par_inject);
      resp_ent_p2                   <= bus.rf_entry;
    end
  end
endmodule

// File: tb/tb_pag_xlate_cache.sv
module tb_pag_xlate_cache;
  localparam int VW = 14;
  localparam int PW = 13;

  logic clk = 1'b0;
  logic reset, sweep_req, busy, par_inject;
  int   checks = 0;
  int   failures = 0;

  pag_xlate_cache_if #(.VPN_W(VW), .PPN_W(PW)) bus ();

  pag_xlate_cache #(.WAYS(2), .SETS_LOG2(7), .VPN_W(VW), .PPN_W(PW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sweep_req(sweep_req), .busy(busy), .par_inject(par_inject)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          user;
    logic [VW-1:0] vpn;
    logic          wr;
    logic          pinj;
    logic          exp_miss;
    logic          err;
    logic [PW+4:0] ent;
    logic          exp_fail;
    logic [4:0]    exp_code;
    logic [PW-1:0] exp_ppn;
  } vec_t;

  function automatic vec_t mkv(logic u, logic [VW-1:0] v, logic w, logic pi, logic miss,
                               logic err, logic acc, logic wrb, logic sw, logic ca,
                               logic [PW-1:0] ppn, logic f, logic [4:0] code,
                               logic [PW-1:0] eppn);
    vec_t t;
    t.user = u; t.vpn = v; t.wr = w; t.pinj = pi; t.exp_miss = miss; t.err = err;
    t.ent = {acc, 1'b0, wrb, sw, ca, ppn};
    t.exp_fail = f; t.exp_code = code; t.exp_ppn = eppn;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = bus.lk_ready;
    end
    chk("lk_ready_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic issue(input logic u, input logic [VW-1:0] v, input logic w, input logic pi);
    wait_ready();
    bus.lk_valid = 1'b1; bus.lk_user = u; bus.lk_vpn = v; bus.lk_write = w; par_inject = pi;
    @(posedge clk); #1;
    bus.lk_valid = 1'b0; par_inject = 1'b0;
  endtask

  task automatic run_vec(input vec_t t, input int id);
    logic missed, got, fl;
    logic [PW-1:0] ppn;
    logic [4:0] code;
    int lat;
    string tag;
    missed = 1'b0; got = 1'b0; lat = 0; fl = 1'b0; ppn = '0; code = '0;
    tag = $sformatf("v%0d", id);
    issue(t.user, t.vpn, t.wr, t.pinj);
    while (!got && lat < 40) begin
      @(negedge clk); lat++;
      if (bus.rsp_valid) begin
        got = 1'b1; ppn = bus.rsp_ppn; fl = bus.rsp_fail; code = bus.rsp_code;
      end else if (bus.rf_req && !missed) begin
        missed = 1'b1;
        chk({tag, "_rf_vpn"}, 32'(bus.rf_vpn), 32'(t.vpn));
        chk({tag, "_rf_user"}, 32'(bus.rf_user), 32'(t.user));
        bus.rf_valid = 1'b1; bus.rf_err = t.err; bus.rf_entry = t.ent;
        @(posedge clk); #1;
        bus.rf_valid = 1'b0; bus.rf_err = 1'b0;
      end
    end
    chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
    chk({tag, "_miss"}, 32'(missed), 32'(t.exp_miss));
    chk({tag, "_fail"}, 32'(fl), 32'(t.exp_fail));
    chk({tag, "_code"}, 32'(code), 32'(t.exp_code));
    chk({tag, "_ppn"}, 32'(ppn), 32'(t.exp_ppn));
    if (!t.exp_miss) chk({tag, "_hit_latency"}, 32'(lat), 32'd2);
  endtask

  vec_t tv [22];
  vec_t pv [5];

  initial begin
    int  n_low;
    logic busy_ok, seen;
    tv[0]  = mkv(1, 14'h0123, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0456, 0, 5'b01100, 13'h0456);
    tv[1]  = mkv(1, 14'h0123, 0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 5'b01100, 13'h0456);
    tv[2]  = mkv(1, 14'h0123, 1, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 5'b01101, 13'h0456);
    tv[3]  = mkv(1, 14'h0040, 1, 0, 1, 0, 1, 0, 0, 0, 13'h0111, 1, 5'b01001, 13'h0111);
    tv[4]  = mkv(1, 14'h0040, 1, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 1, 5'b01001, 13'h0111);
    tv[5]  = mkv(0, 14'h0040, 0, 0, 1, 0, 1, 1, 0, 0, 13'h0222, 0, 5'b01100, 13'h0222);
    tv[6]  = mkv(1, 14'h0040, 0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 5'b01000, 13'h0111);
    tv[7]  = mkv(1, 14'h0005, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0A05, 0, 5'b01100, 13'h0A05);
    tv[8]  = mkv(1, 14'h0085, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0A85, 0, 5'b01100, 13'h0A85);
    tv[9]  = mkv(1, 14'h0105, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0B05, 0, 5'b01100, 13'h0B05);
    tv[10] = mkv(1, 14'h0185, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0B85, 0, 5'b01100, 13'h0B85);
    tv[11] = mkv(1, 14'h0105, 0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 5'b01100, 13'h0B05);
    tv[12] = mkv(1, 14'h0185, 0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 5'b01100, 13'h0B85);
    tv[13] = mkv(1, 14'h0005, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0C05, 0, 5'b01100, 13'h0C05);
    tv[14] = mkv(1, 14'h0085, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0C85, 0, 5'b01100, 13'h0C85);
    tv[15] = mkv(1, 14'h0033, 0, 1, 1, 0, 1, 1, 0, 1, 13'h0333, 0, 5'b01100, 13'h0333);
    tv[16] = mkv(1, 14'h0033, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0334, 0, 5'b01100, 13'h0334);
    tv[17] = mkv(1, 14'h0033, 0, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 5'b01100, 13'h0334);
    tv[18] = mkv(1, 14'h0077, 0, 0, 1, 1, 0, 0, 0, 0, 13'h0000, 1, 5'b10000, 13'h0000);
    tv[19] = mkv(1, 14'h0077, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0777, 0, 5'b01100, 13'h0777);
    tv[20] = mkv(1, 14'h0077, 1, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 5'b01101, 13'h0777);
    tv[21] = mkv(1, 14'h0011, 0, 0, 1, 0, 0, 0, 1, 0, 13'h0011, 1, 5'b00010, 13'h0011);
    pv[0]  = mkv(1, 14'h0123, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0999, 0, 5'b01100, 13'h0999);
    pv[1]  = mkv(1, 14'h0040, 1, 0, 1, 0, 1, 1, 0, 1, 13'h0998, 0, 5'b01101, 13'h0998);
    pv[2]  = mkv(1, 14'h0105, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0997, 0, 5'b01100, 13'h0997);
    pv[3]  = mkv(1, 14'h0050, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0996, 0, 5'b01100, 13'h0996);
    pv[4]  = mkv(1, 14'h0060, 0, 0, 1, 0, 1, 1, 0, 1, 13'h0995, 0, 5'b01100, 13'h0995);

    bus.lk_valid = 1'b0; bus.lk_user = 1'b0; bus.lk_vpn = '0; bus.lk_write = 1'b0;
    bus.rf_valid = 1'b0; bus.rf_err = 1'b0; bus.rf_entry = '0;
    sweep_req = 1'b0; par_inject = 1'b0;

    // Reset with lk_valid held; sweep must keep lk_ready low for 128 cycles.
    reset = 1'b1; bus.lk_valid = 1'b1; bus.lk_vpn = 14'h0123; bus.lk_user = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lk_ready", 32'(bus.lk_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rf_req", 32'(bus.rf_req), 32'd0);
    chk("rst_rsp_ppn", 32'(bus.rsp_ppn), 32'd0);
    chk("rst_rsp_fail", 32'(bus.rsp_fail), 32'd0);
    reset = 1'b0;
    n_low = 0; busy_ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (bus.lk_ready) break;
      n_low++;
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
    end
    bus.lk_valid = 1'b0;
    chk("init_sweep_cycles", 32'(n_low), 32'd128);
    chk("init_sweep_busy_high", 32'(busy_ok), 32'd1);
    chk("init_sweep_busy_falls", 32'(busy), 32'd0);

    for (int i = 0; i < 22; i++) run_vec(tv[i], i);

    // Sweep request while a refill is outstanding.
    issue(1'b1, 14'h0050, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rf_req;
    end
    chk("swp_rf_req", 32'(seen), 32'd1);
    sweep_req = 1'b1;
    @(posedge clk); #1;
    sweep_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("swp_busy_in_refill", 32'(busy), 32'd1);
    chk("swp_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
    bus.rf_valid = 1'b1; bus.rf_err = 1'b0; bus.rf_entry = {5'b10101, 13'h0550};
    @(posedge clk); #1;
    bus.rf_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rsp_valid;
    end
    chk("swp_rsp_first", 32'(seen), 32'd1);
    chk("swp_rsp_ppn", 32'(bus.rsp_ppn), 32'h0550);
    n_low = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.lk_ready) break;
      n_low++;
      @(negedge clk);
    end
    chk("swp_blocked_cycles", 32'(n_low), 32'd129);

    for (int i = 0; i < 4; i++) run_vec(pv[i], 100 + i);

    // Reset while waiting for refill data: request drops, no response.
    issue(1'b1, 14'h0060, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rf_req;
    end
    chk("rstmid_rf_req", 32'(seen), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_rf_req_drop", 32'(bus.rf_req), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("rstmid_no_rsp", 32'(seen), 32'd0);
    run_vec(pv[4], 104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
